ib_exp_master: RTL and testbench

- Initiator side of the 4-bit IB expander bus (8243-style P2 nibble bus with PROG strobe). It drives the port that the expander responder serves.
- Accepts one command per handshake: op, port and write nibble.
- Sequences P2 and PROG with parameterised cycle timing, and returns the read nibble for read ops.
- Used by bench/host-side logic to exercise the meter-facing expander path, and as the controller when the FPGA talks to a real expander.

---
 rtl/ib_pkg.sv | 36 +++
 rtl/ib_exp_master.sv | 137 +++++++++++++
 tb/tb_ib_exp_master.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ib_pkg.sv
// Shared types for the IB expander bus: op codes, port numbers and the
// initiator state encoding.
package ib_pkg;

  // Bus op codes, shared with the expander responder.
  typedef enum logic [1:0] {
    IB_READ  = 2'b00,
    IB_WRITE = 2'b01,
    IB_OR    = 2'b10,
    IB_AND   = 2'b11
  } ib_op_t;

  // Expander port number 0..3 (P4..P7).
  typedef logic [1:0] ib_port_t;

  // Phases of one initiator transfer.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RECOVER = 2'd3
  } ib_mst_state_t;

  localparam int IB_NIBBLE_W = 4;

  // Largest of four timing parameters; sizes the shared phase counter.
  function automatic int ib_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ib_exp_master.sv
// Initiator for the 4-bit IB expander bus. Takes one command per handshake,
// drives the {op,port} address nibble on P2, strobes PROG low, then either
// drives the data nibble or turns the bus around and samples the read nibble.
module ib_exp_master
  import ib_pkg::*;
#(
  parameter int T_SETUP = 2,
  parameter int T_AHOLD = 1,
  parameter int T_LOW   = 8,
  parameter int T_REC   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [1:0]             cmd_port,
  input  logic [IB_NIBBLE_W-1:0] cmd_data,
  output logic                   rsp_valid,
  output logic [IB_NIBBLE_W-1:0] rsp_data,
  output logic                   busy,
  output logic [IB_NIBBLE_W-1:0] p2_o,
  output logic                   p2_oe,
  input  logic [IB_NIBBLE_W-1:0] p2_i,
  output logic                   prog_o
);

  localparam int MAX_T = ib_max4(T_SETUP, T_AHOLD, T_LOW, T_REC);
  localparam int CNT_W = $clog2(MAX_T + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  // Each phase loads its length minus one and ends when the counter hits zero.
  localparam cnt_t SETUP_LOAD = cnt_t'(T_SETUP - 1);
  localparam cnt_t LOW_LOAD   = cnt_t'(T_LOW - 1);
  localparam cnt_t REC_LOAD   = cnt_t'(T_REC - 1);
  // While the STROBE counter is above this value, the next cycle still
  // belongs to the address-hold window.
  localparam cnt_t ADDR_LAST  = cnt_t'(T_LOW - T_AHOLD);

  // Refuse to elaborate with timing that would collapse a phase or leave no
  // data window after the address hold.
  if (T_SETUP < 1 || T_AHOLD < 1 || T_LOW < 1 || T_REC < 1 || T_AHOLD >= T_LOW) begin : g_param_check
    $error("ib_exp_master: illegal timing parameters");
  end

  ib_mst_state_t          state;
  cnt_t                   count;
  ib_op_t                 op_q;
  logic [IB_NIBBLE_W-1:0] addr_q;
  logic [IB_NIBBLE_W-1:0] data_q;

  // Single transfer sequencer: every output is registered and computed for
  // the cycle after the edge, so the bus never glitches between phases.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      p2_o      <= '0;
      p2_oe     <= 1'b0;
      prog_o    <= 1'b1;
      op_q      <= IB_READ;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q      <= ib_op_t'(cmd_op);
            addr_q    <= {cmd_op, cmd_port};
            data_q    <= cmd_data;
            p2_o      <= {cmd_op, cmd_port};
            p2_oe     <= 1'b1;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            count     <= SETUP_LOAD;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (count == '0) begin
            prog_o <= 1'b0;
            count  <= LOW_LOAD;
            state  <= ST_STROBE;
          end else begin
            count <= count - 1'b1;
          end
        end
        ST_STROBE: begin
          if (count == '0) begin
            prog_o <= 1'b1;
            count  <= REC_LOAD;
            state  <= ST_RECOVER;
            if (op_q == IB_READ) begin
              rsp_valid <= 1'b1;
              rsp_data  <= p2_i;
              p2_oe     <= 1'b0;
            end else begin
              p2_oe <= 1'b1;
              p2_o  <= data_q;
            end
          end else begin
            count <= count - 1'b1;
            if (count > ADDR_LAST) begin
              p2_oe <= 1'b1;
              p2_o  <= addr_q;
            end else if (op_q == IB_READ) begin
              p2_oe <= 1'b0;
            end else begin
              p2_oe <= 1'b1;
              p2_o  <= data_q;
            end
          end
        end
        ST_RECOVER: begin
          p2_oe <= 1'b0;
          if (count == '0) begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ib_exp_master.sv
// Self-checking bench for ib_exp_master: a default-timing instance (A) and a
// short-timing instance (B), each tracked by a cycle-offset model of the bus.
module tb_ib_exp_master;

  localparam int A_TS = 2, A_TA = 1, A_TL = 8, A_TR = 2;
  localparam int B_TS = 1, B_TA = 2, B_TL = 3, B_TR = 1;

  typedef struct {
    bit         active;
    int         t;
    logic [1:0] op;
    logic [1:0] port;
    logic [3:0] data;
    logic [3:0] rsp;
  } mstate_t;

  typedef struct packed {
    logic       ready;
    logic       prog;
    logic       oe;
    logic [3:0] p2o;
    logic       rv;
  } exp_t;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  logic       rst_a, valid_a, ready_a, rv_a, busy_a, oe_a, prog_a;
  logic [1:0] op_a, port_a;
  logic [3:0] data_a, rsp_a, p2o_a, p2i_a;

  logic       rst_b, valid_b, ready_b, rv_b, busy_b, oe_b, prog_b;
  logic [1:0] op_b, port_b;
  logic [3:0] data_b, rsp_b, p2o_b, p2i_b;

  mstate_t ms_a, ms_b;
  bit      armed_a = 0, armed_b = 0;

  ib_exp_master #(.T_SETUP(A_TS), .T_AHOLD(A_TA), .T_LOW(A_TL), .T_REC(A_TR)) dut_a (
    .clk(clk), .rst(rst_a), .cmd_valid(valid_a), .cmd_ready(ready_a),
    .cmd_op(op_a), .cmd_port(port_a), .cmd_data(data_a),
    .rsp_valid(rv_a), .rsp_data(rsp_a), .busy(busy_a),
    .p2_o(p2o_a), .p2_oe(oe_a), .p2_i(p2i_a), .prog_o(prog_a)
  );

  ib_exp_master #(.T_SETUP(B_TS), .T_AHOLD(B_TA), .T_LOW(B_TL), .T_REC(B_TR)) dut_b (
    .clk(clk), .rst(rst_b), .cmd_valid(valid_b), .cmd_ready(ready_b),
    .cmd_op(op_b), .cmd_port(port_b), .cmd_data(data_b),
    .rsp_valid(rv_b), .rsp_data(rsp_b), .busy(busy_b),
    .p2_o(p2o_b), .p2_oe(oe_b), .p2_i(p2i_b), .prog_o(prog_b)
  );

  // Free-running system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance the model one clock: t counts cycles since the accept edge,
  // a read samples P2 at the end of the last PROG-low cycle.
  function automatic mstate_t model_step(input mstate_t s, input logic rst, input logic valid,
                                         input logic [1:0] op, input logic [1:0] port,
                                         input logic [3:0] data, input logic [3:0] p2i,
                                         input int ts, input int tl, input int tr);
    mstate_t n;
    n = s;
    if (rst) begin
      n.active = 0;
      n.t      = 0;
      n.rsp    = 4'h0;
      return n;
    end
    if (s.active && s.op == 2'b00 && s.t == ts + tl) n.rsp = p2i;
    if (!s.active) begin
      if (valid) begin
        n.active = 1;
        n.t      = 1;
        n.op     = op;
        n.port   = port;
        n.data   = data;
      end
    end else if (s.t == ts + tl + tr) begin
      n.active = 0;
    end else begin
      n.t = s.t + 1;
    end
    return n;
  endfunction

  // Expected bus outputs for the current cycle from the cycle offset alone.
  function automatic exp_t model_out(input mstate_t s, input int ts, input int ta, input int tl);
    exp_t e;
    int   k;
    e = '{ready: 1'b1, prog: 1'b1, oe: 1'b0, p2o: 4'h0, rv: 1'b0};
    if (s.active) begin
      e.ready = 1'b0;
      if (s.t <= ts) begin
        e.oe  = 1'b1;
        e.p2o = {s.op, s.port};
      end else if (s.t <= ts + tl) begin
        e.prog = 1'b0;
        k = s.t - ts - 1;
        if (k < ta) begin
          e.oe  = 1'b1;
          e.p2o = {s.op, s.port};
        end else if (s.op != 2'b00) begin
          e.oe  = 1'b1;
          e.p2o = s.data;
        end
      end else begin
        k = s.t - ts - tl - 1;
        if (k == 0 && s.op != 2'b00) begin
          e.oe  = 1'b1;
          e.p2o = s.data;
        end
        if (k == 0 && s.op == 2'b00) e.rv = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareAll(input string tag, input exp_t e, input logic [3:0] rsp_exp,
                            input logic ready, input logic busy, input logic prog,
                            input logic oe, input logic [3:0] p2o, input logic rv,
                            input logic [3:0] rsp);
    checkOutput({tag, ".cmd_ready"}, ready, e.ready);
    checkOutput({tag, ".busy"}, busy, !e.ready);
    checkOutput({tag, ".prog_o"}, prog, e.prog);
    checkOutput({tag, ".p2_oe"}, oe, e.oe);
    if (e.oe) checkOutput({tag, ".p2_o"}, p2o, e.p2o);
    checkOutput({tag, ".rsp_valid"}, rv, e.rv);
    checkOutput({tag, ".rsp_data"}, rsp, rsp_exp);
  endtask

  // Model for instance A follows the inputs on every rising edge.
  always @(posedge clk) begin
    if (rst_a) armed_a = 1;
    ms_a = model_step(ms_a, rst_a, valid_a, op_a, port_a, data_a, p2i_a, A_TS, A_TL, A_TR);
  end

  // Model for instance B follows the inputs on every rising edge.
  always @(posedge clk) begin
    if (rst_b) armed_b = 1;
    ms_b = model_step(ms_b, rst_b, valid_b, op_b, port_b, data_b, p2i_b, B_TS, B_TL, B_TR);
  end

  // Compare instance A against its model mid-cycle once reset has been seen.
  always @(negedge clk) begin
    if (armed_a)
      compareAll("A", model_out(ms_a, A_TS, A_TA, A_TL), ms_a.rsp,
                 ready_a, busy_a, prog_a, oe_a, p2o_a, rv_a, rsp_a);
  end

  // Compare instance B against its model mid-cycle once reset has been seen.
  always @(negedge clk) begin
    if (armed_b)
      compareAll("B", model_out(ms_b, B_TS, B_TA, B_TL), ms_b.rsp,
                 ready_b, busy_b, prog_b, oe_b, p2o_b, rv_b, rsp_b);
  end

  // Hand one command to A from an idle cycle; returns at the start of cycle 1.
  task automatic applyStimulus(input logic [1:0] op, input logic [1:0] port, input logic [3:0] data);
    valid_a = 1'b1;
    op_a    = op;
    port_a  = port;
    data_a  = data;
    @(posedge clk); #1;
    valid_a = 1'b0;
    op_a    = ~op;
    port_a  = ~port;
    data_a  = ~data;
  endtask

  // Hand one command to B from an idle cycle; returns at the start of cycle 1.
  task automatic applyStimulusB(input logic [1:0] op, input logic [1:0] port, input logic [3:0] data);
    valid_b = 1'b1;
    op_b    = op;
    port_b  = port;
    data_b  = data;
    @(posedge clk); #1;
    valid_b = 1'b0;
    op_b    = ~op;
    port_b  = ~port;
    data_b  = ~data;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [12:0] prog_tab, oe_tab, ready_tab;
    logic [5:0]  bprog_tab, boe_tab;
    int          falls, rv_seen;
    logic        prev_prog;

    rst_a = 1; valid_a = 0; op_a = 0; port_a = 0; data_a = 0; p2i_a = 0;
    rst_b = 1; valid_b = 0; op_b = 0; port_b = 0; data_b = 0; p2i_b = 0;
    ms_a = '{active: 0, t: 0, op: 2'b00, port: 2'b00, data: 4'h0, rsp: 4'h0};
    ms_b = ms_a;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 0;
    rst_b = 0;

    @(negedge clk);
    checkOutput("lit_rst_ready", ready_a, 1);
    checkOutput("lit_rst_busy", busy_a, 0);
    checkOutput("lit_rst_prog", prog_a, 1);
    checkOutput("lit_rst_oe", oe_a, 0);
    checkOutput("lit_rst_p2o", p2o_a, 0);
    checkOutput("lit_rst_rsp", rsp_a, 0);
    checkOutput("lit_rst_b_ready", ready_b, 1);
    @(posedge clk); #1;

    $display("[TB] write op=01 port=2 data=A");
    prog_tab  = 13'h1C03;
    oe_tab    = 13'h07FF;
    ready_tab = 13'h1000;
    applyStimulus(2'b01, 2'd2, 4'hA);
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      checkOutput("lit_wr_prog", prog_a, prog_tab[i-1]);
      checkOutput("lit_wr_oe", oe_a, oe_tab[i-1]);
      checkOutput("lit_wr_ready", ready_a, ready_tab[i-1]);
      if (oe_tab[i-1]) checkOutput("lit_wr_p2o", p2o_a, (i <= 3) ? 4'h6 : 4'hA);
      @(posedge clk); #1;
    end

    $display("[TB] read op=00 port=0");
    p2i_a = 4'hA;
    applyStimulus(2'b00, 2'd0, 4'hF);
    for (int i = 1; i <= 12; i++) begin
      p2i_a = (i >= 4 && i <= 10) ? 4'h5 : 4'hA;
      @(negedge clk);
      if (i >= 4 && i <= 10) checkOutput("lit_rd_turn", oe_a, 0);
      if (i == 10) checkOutput("lit_rd_early", rv_a, 0);
      if (i == 11) begin
        checkOutput("lit_rd_valid", rv_a, 1);
        checkOutput("lit_rd_data", rsp_a, 4'h5);
      end
      @(posedge clk); #1;
    end

    $display("[TB] back-to-back write then read");
    p2i_a   = 4'h7;
    valid_a = 1'b1; op_a = 2'b01; port_a = 2'd1; data_a = 4'h3;
    @(posedge clk); #1;
    op_a = 2'b00; port_a = 2'd3; data_a = 4'h0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 12) checkOutput("lit_b2b_busy", ready_a, 0);
      if (i == 13) checkOutput("lit_b2b_ready", ready_a, 1);
      if (i == 14) begin
        checkOutput("lit_b2b_accept", ready_a, 0);
        checkOutput("lit_b2b_addr", p2o_a, 4'h3);
        checkOutput("lit_b2b_oe", oe_a, 1);
      end
      @(posedge clk); #1;
      if (i == 13) valid_a = 1'b0;
    end
    idleCycles(12);
    @(negedge clk);
    checkOutput("lit_b2b_rsp", rsp_a, 4'h7);
    @(posedge clk); #1;

    $display("[TB] busy drop");
    applyStimulus(2'b01, 2'd1, 4'h5);
    falls = 0; rv_seen = 0; prev_prog = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      if (i == 5) begin valid_a = 1'b1; op_a = 2'b10; port_a = 2'd2; data_a = 4'h1; end
      if (i == 6) valid_a = 1'b0;
      @(negedge clk);
      if (prev_prog && !prog_a) falls++;
      if (rv_a) rv_seen++;
      prev_prog = prog_a;
      @(posedge clk); #1;
    end
    checkOutput("lit_busy_pulses", falls, 1);
    checkOutput("lit_busy_rsp", rv_seen, 0);

    $display("[TB] reset mid-strobe");
    applyStimulus(2'b01, 2'd0, 4'h9);
    idleCycles(6);
    rst_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b1; op_a = 2'b01; port_a = 2'd3; data_a = 4'h2;
    @(negedge clk);
    checkOutput("lit_abort_prog", prog_a, 1);
    checkOutput("lit_abort_oe", oe_a, 0);
    checkOutput("lit_abort_ready", ready_a, 1);
    @(posedge clk); #1;
    rst_a = 1'b0; valid_a = 1'b0;
    @(negedge clk);
    checkOutput("lit_rstdrop_ready", ready_a, 1);
    checkOutput("lit_rstdrop_prog", prog_a, 1);
    @(posedge clk); #1;
    p2i_a = 4'hC;
    applyStimulus(2'b00, 2'd2, 4'h0);
    idleCycles(12);
    @(negedge clk);
    checkOutput("lit_post_rst_rsp", rsp_a, 4'hC);
    @(posedge clk); #1;

    $display("[TB] short timing instance");
    bprog_tab = 6'b110001;
    boe_tab   = 6'b011111;
    applyStimulusB(2'b01, 2'd0, 4'hF);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      checkOutput("lit_b_prog", prog_b, bprog_tab[i-1]);
      checkOutput("lit_b_oe", oe_b, boe_tab[i-1]);
      checkOutput("lit_b_ready", ready_b, (i == 6) ? 1 : 0);
      if (boe_tab[i-1]) checkOutput("lit_b_p2o", p2o_b, (i <= 3) ? 4'h4 : 4'hF);
      @(posedge clk); #1;
    end
    applyStimulusB(2'b00, 2'd1, 4'h0);
    for (int i = 1; i <= 6; i++) begin
      p2i_b = (i == 4) ? 4'hB : 4'h0;
      @(negedge clk);
      if (i == 5) begin
        checkOutput("lit_b_rd_valid", rv_b, 1);
        checkOutput("lit_b_rd_data", rsp_b, 4'hB);
      end
      if (i == 6) checkOutput("lit_b_rd_ready", ready_b, 1);
      @(posedge clk); #1;
    end

    idleCycles(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
